double_buffer_sequencer: RTL and testbench

Sequences a two-half (ping-pong) Avalon-MM agent memory shared between a streaming producer and an HLS component that processes one half per invocation. It writes incoming words into the half the component is not using. When a half is complete, it launches the component on that half with the matching `db_data` select. It collects the component's return value and recycles the half, so filling and processing overlap continuously.

---
 rtl/double_buffer_sequencer_if.sv | 43 ++++
 rtl/double_buffer_sequencer.sv | 140 ++++++++++++++
 tb/tb_double_buffer_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/double_buffer_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// double_buffer_sequencer_if : producer / agent-memory / call / return bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface double_buffer_sequencer_if #(
  parameter int HALF_DEPTH = 256,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9
);
  localparam int c_LVL_W = $clog2(HALF_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_writedata;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic                  call_valid;
  logic                  call_stall;
  logic                  db_data;
  logic                  return_valid;
  logic                  return_stall;
  logic [DATA_W-1:0]     returndata_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_data;
  logic [c_LVL_W-1:0]    fill_level;

  modport master (
    input  in_valid, in_data, call_stall, return_valid, returndata_data, res_ready,
    output in_ready, mem_write, mem_address, mem_writedata, mem_byteenable,
           call_valid, db_data, return_stall, res_valid, res_data, fill_level
  );

  modport slave (
    output in_valid, in_data, call_stall, return_valid, returndata_data, res_ready,
    input  in_ready, mem_write, mem_address, mem_writedata, mem_byteenable,
           call_valid, db_data, return_stall, res_valid, res_data, fill_level
  );
endinterface
`default_nettype wire

// File: rtl/double_buffer_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// double_buffer_sequencer : fills one memory half while the component runs on
// the other, launching a call per completed half. Rev 1.0
// ----------------------------------------------------------------------------
module double_buffer_sequencer #(
  parameter int HALF_DEPTH = 256,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  double_buffer_sequencer_if.master bus
);
  localparam int c_IDX_W = $clog2(HALF_DEPTH);
  localparam int c_LVL_W = c_IDX_W + 1;
  localparam logic [c_LVL_W-1:0] c_LAST_IDX = c_LVL_W'(HALF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_PROC    = 2'd3
  } half_state_e;

  half_state_e         state_q [2];
  half_state_e         state_d [2];
  logic                fill_half_q, fill_half_d;
  logic                comp_half_q, comp_half_d;
  logic [c_LVL_W-1:0]  fill_level_q, fill_level_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
  logic                call_valid_q, call_valid_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  logic w_in_ready;
  logic w_accept;
  logic w_last_word;
  logic w_return_stall;
  logic w_return_accept;

  assign w_in_ready      = ((state_q[fill_half_q] == ST_EMPTY) ||
                            (state_q[fill_half_q] == ST_FILLING)) && !reset;
  assign w_accept        = bus.in_valid && w_in_ready;
  assign w_last_word     = (fill_level_q == c_LAST_IDX);
  assign w_return_stall  = res_valid_q && !bus.res_ready;
  assign w_return_accept = bus.return_valid && !w_return_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q[0]      <= ST_EMPTY;
      state_q[1]      <= ST_EMPTY;
      fill_half_q     <= 1'b0;
      comp_half_q     <= 1'b0;
      fill_level_q    <= '0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      call_valid_q    <= 1'b0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
    end else begin
      state_q[0]      <= state_d[0];
      state_q[1]      <= state_d[1];
      fill_half_q     <= fill_half_d;
      comp_half_q     <= comp_half_d;
      fill_level_q    <= fill_level_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      call_valid_q    <= call_valid_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
    end
  end

  // Fill, launch and return touch disjoint halves (EMPTY/FILLING vs FULL/PROC),
  // so all three may update state_d on the same edge without conflict.
  always_comb begin
    state_d[0]      = state_q[0];
    state_d[1]      = state_q[1];
    fill_half_d     = fill_half_q;
    comp_half_d     = comp_half_q;
    fill_level_d    = fill_level_q;
    mem_write_d     = w_accept;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    call_valid_d    = call_valid_q;
    res_valid_d     = res_valid_q;
    res_data_d      = res_data_q;

    if (w_accept) begin
      mem_address_d   = ADDR_W'({fill_half_q, fill_level_q[c_IDX_W-1:0]});
      mem_writedata_d = bus.in_data;
      if (w_last_word) begin
        state_d[fill_half_q] = ST_FULL;
        fill_level_d         = '0;
        fill_half_d          = !fill_half_q;
      end else begin
        state_d[fill_half_q] = ST_FILLING;
        fill_level_d         = fill_level_q + c_LVL_W'(1);
      end
    end

    // Launch decision uses registered state, so a call trails the last write.
    if (call_valid_q) begin
      if (!bus.call_stall) begin
        call_valid_d         = 1'b0;
        state_d[comp_half_q] = ST_PROC;
      end
    end else if (state_q[comp_half_q] == ST_FULL) begin
      call_valid_d = 1'b1;
    end

    if (w_return_accept) begin
      res_data_d           = bus.returndata_data;
      res_valid_d          = 1'b1;
      state_d[comp_half_q] = ST_EMPTY;
      comp_half_d          = !comp_half_q;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_writedata  = mem_writedata_q;
  assign bus.mem_byteenable = '1;
  assign bus.call_valid     = call_valid_q;
  assign bus.db_data        = comp_half_q;
  assign bus.return_stall   = w_return_stall;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.fill_level     = fill_level_q;

endmodule
`default_nettype wire

// File: tb/tb_double_buffer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_double_buffer_sequencer : random stimulus against a counter-based model
// of the ping-pong sequencer, with a summing component model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_double_buffer_sequencer;
  localparam int HALF_DEPTH = 256;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;

  logic clk = 1'b0;
  logic reset;

  double_buffer_sequencer_if #(.HALF_DEPTH(HALF_DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  double_buffer_sequencer #(.HALF_DEPTH(HALF_DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: counts of accepted words, launched calls and accepted returns.
  logic [DATA_W-1:0] tbmem [2*HALF_DEPTH];
  int                wcount, calls, rets;
  logic              exp_mw, exp_cv, exp_rv;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wd, exp_rd, cur_sum;
  logic [DATA_W-1:0] exp_sums [$];
  logic [DATA_W-1:0] obs_res  [$];

  int  p_valid, p_ready, stall_mode, stall_n, dly_min, dly_max;
  bit  seq_data;
  int  words_left, phase_acc, ready_gaps;

  bit                comp_busy, ret_take;
  int                comp_cnt, stall_cnt;
  logic [DATA_W-1:0] comp_sum;
  logic [DATA_W/8-1:0] be_ones;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcount = 0; calls = 0; rets = 0;
    exp_mw = 1'b0; exp_cv = 1'b0; exp_rv = 1'b0;
    exp_addr = '0; exp_wd = '0; exp_rd = '0; cur_sum = '0;
    exp_sums.delete();
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    bus.in_valid        = 1'b0;
    bus.in_data         = '0;
    bus.call_stall      = 1'b0;
    bus.return_valid    = 1'b0;
    bus.returndata_data = '0;
    bus.res_ready       = 1'b1;
    comp_busy = 1'b0; ret_take = 1'b0; comp_cnt = 0; stall_cnt = 0;
    #1;
    check_eq("rst_in_ready",   bus.in_ready, 0);
    check_eq("rst_mem_write",  bus.mem_write, 0);
    check_eq("rst_mem_addr",   bus.mem_address, 0);
    check_eq("rst_mem_wdata",  bus.mem_writedata, 0);
    check_eq("rst_call_valid", bus.call_valid, 0);
    check_eq("rst_db_data",    bus.db_data, 0);
    check_eq("rst_res_valid",  bus.res_valid, 0);
    check_eq("rst_res_data",   bus.res_data, 0);
    check_eq("rst_fill_level", bus.fill_level, 0);
    check_eq("byteenable",     bus.mem_byteenable, be_ones);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_inputs();
    if (words_left > 0 && $urandom_range(99) < p_valid) begin
      bus.in_valid = 1'b1;
      bus.in_data  = seq_data ? DATA_W'(phase_acc) : DATA_W'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.res_ready = ($urandom_range(99) < p_ready);

    // Component return side.
    if (ret_take) begin
      bus.return_valid = 1'b0;
      comp_busy        = 1'b0;
      ret_take         = 1'b0;
    end else if (comp_busy && !bus.return_valid) begin
      if (comp_cnt == 0) begin
        bus.return_valid    = 1'b1;
        bus.returndata_data = comp_sum;
      end else begin
        comp_cnt--;
      end
    end
    if (bus.return_valid && !(bus.res_valid && !bus.res_ready)) ret_take = 1'b1;

    // Component call side.
    if (!bus.call_valid) stall_cnt = 0;
    case (stall_mode)
      0:       bus.call_stall = 1'b0;
      1:       bus.call_stall = (stall_cnt < stall_n);
      default: bus.call_stall = ($urandom_range(99) < 30);
    endcase
    if (bus.call_valid) stall_cnt++;
    if (bus.call_valid && !bus.call_stall && !comp_busy) begin
      comp_busy = 1'b1;
      comp_cnt  = $urandom_range(dly_max, dly_min);
      comp_sum  = '0;
      for (int i = 0; i < HALF_DEPTH; i++)
        comp_sum += tbmem[int'(bus.db_data) * HALF_DEPTH + i];
    end
  endtask

  task automatic step();
    bit in_rdy, acc, call_acc, ret_acc, cond_pre;
    @(negedge clk);
    check_eq("mem_write", bus.mem_write, exp_mw);
    if (exp_mw) begin
      check_eq("mem_address",   bus.mem_address, exp_addr);
      check_eq("mem_writedata", bus.mem_writedata, exp_wd);
    end
    if (bus.mem_write) tbmem[bus.mem_address] = bus.mem_writedata;
    check_eq("fill_level", bus.fill_level, wcount % HALF_DEPTH);
    in_rdy = ((wcount / HALF_DEPTH) - rets) < 2;
    check_eq("in_ready", bus.in_ready, in_rdy);
    if (!bus.in_ready && words_left > 0) ready_gaps++;
    check_eq("call_valid", bus.call_valid, exp_cv);
    check_eq("db_data", bus.db_data, rets % 2);
    check_eq("res_valid", bus.res_valid, exp_rv);
    check_eq("return_stall", bus.return_stall, exp_rv && !bus.res_ready);
    if (exp_rv) check_eq("res_data", bus.res_data, exp_rd);

    drive_inputs();

    acc      = bus.in_valid && in_rdy;
    call_acc = exp_cv && !bus.call_stall;
    ret_acc  = bus.return_valid && !(exp_rv && !bus.res_ready);
    cond_pre = ((wcount / HALF_DEPTH) > calls) && (calls == rets);
    if (exp_rv && bus.res_ready) begin
      obs_res.push_back(bus.res_data);
      check_eq("results_outstanding", exp_sums.size() > 0, 1);
      if (exp_sums.size() > 0) check_eq("result_sum", bus.res_data, exp_sums.pop_front());
    end
    if (acc) begin
      exp_addr = ADDR_W'(wcount % (2 * HALF_DEPTH));
      exp_wd   = bus.in_data;
      cur_sum += bus.in_data;
      wcount++;
      phase_acc++;
      words_left--;
      if (wcount % HALF_DEPTH == 0) begin
        exp_sums.push_back(cur_sum);
        cur_sum = '0;
      end
    end
    exp_mw = acc;
    exp_cv = cond_pre && !call_acc;
    if (ret_acc) exp_rd = bus.returndata_data;
    exp_rv = ret_acc || (exp_rv && !bus.res_ready);
    calls += int'(call_acc);
    rets  += int'(ret_acc);
  endtask

  task automatic run_phase(input string name, input int nwords, input int budget);
    int cyc = 0;
    words_left = nwords; phase_acc = 0; ready_gaps = 0;
    obs_res.delete();
    while (!(words_left == 0 && (wcount / HALF_DEPTH) == rets && exp_sums.size() == 0 && !exp_rv)
           && cyc < budget) begin
      step();
      cyc++;
    end
    check_eq({"drained_", name}, cyc < budget, 1);
  endtask

  task automatic run_words(input string name, input int nwords, input int budget);
    int cyc = 0;
    words_left = nwords; phase_acc = 0;
    while (words_left > 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check_eq({"words_", name}, cyc < budget, 1);
  endtask

  task automatic set_knobs(input int pv, input int pr, input int sm, input int sn,
                           input int dmin, input int dmax, input bit sq);
    p_valid = pv; p_ready = pr; stall_mode = sm; stall_n = sn;
    dly_min = dmin; dly_max = dmax; seq_data = sq;
  endtask

  initial begin
    be_ones = '1;
    reset   = 1'b0;
    set_knobs(100, 100, 0, 0, 2, 2, 1'b1);
    words_left = 0; phase_acc = 0; ready_gaps = 0;
    #1;
    do_reset();

    // Streaming sum of 0..511.
    run_phase("stream", 512, 3000);
    check_eq("stream_nres", obs_res.size(), 2);
    if (obs_res.size() >= 2) begin
      check_eq("stream_sum0", obs_res[0], 32640);
      check_eq("stream_sum1", obs_res[1], 98176);
    end

    // Slow component: producer must stall once both halves are occupied.
    set_knobs(100, 100, 0, 0, 600, 600, 1'b1);
    run_phase("backpressure", 768, 5000);
    check_eq("bp_ready_dropped", ready_gaps > 0, 1);

    // Component refuses the call for 5 cycles.
    set_knobs(100, 100, 1, 5, 3, 3, 1'b1);
    run_phase("call_stall", 512, 3000);
    check_eq("stall_nres", obs_res.size(), 2);

    // Returns land on the same edge as each half completes.
    set_knobs(100, 100, 0, 0, 253, 253, 1'b1);
    run_phase("simultaneous", 1024, 3000);
    check_eq("simul_no_gap", ready_gaps, 0);

    // Random traffic with result backpressure and random call stalls.
    set_knobs(70, 60, 2, 0, 0, 40, 1'b0);
    run_phase("random", 1300, 30000);
    check_eq("random_nres", obs_res.size(), 5);

    // Reset in the middle of a fill, then resume cleanly.
    set_knobs(100, 100, 0, 0, 2, 2, 1'b1);
    run_words("pre_reset", 100, 500);
    do_reset();
    run_phase("post_reset", 512, 3000);
    check_eq("post_reset_nres", obs_res.size(), 2);
    if (obs_res.size() >= 1) check_eq("post_reset_sum0", obs_res[0], 32640);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
